display_scan_ctrl: RTL and testbench



---
 rtl/display_pkg.sv | 23 ++
 rtl/scan_prescaler.sv | 57 +++++
 rtl/display_scan_ctrl.sv | 117 +++++++++++
 tb/tb_display_scan_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and segment constants for the 7-segment display scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Entry [n] is the active-high a..g pattern for BCD digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    if (bcd > 4'd9) return SEG_DASH;
    return SEG_TABLE[bcd];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter and digit index for the display scanner; one slot is PRESCALE
// cycles, the first BLANK_CYCLES of which are dead-time.
module scan_prescaler #(
  parameter int  NUM_DIGITS   = 4,
  parameter int  PRESCALE     = 1024,
  parameter int  BLANK_CYCLES = 16,
  localparam int CW           = $clog2(PRESCALE),
  localparam int DW           = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          run_i,
  output logic          blank_done_o,
  output logic          slot_done_o,
  output logic          wrap_o,
  output logic [DW-1:0] digit_o,
  output logic [DW-1:0] digit_nxt_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] digit_q, digit_d;

  assign blank_done_o = (cnt_q == CW'(BLANK_CYCLES - 1));
  assign slot_done_o  = (cnt_q == CW'(PRESCALE - 1));
  assign wrap_o       = slot_done_o && (digit_q == DW'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (clear_i) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (run_i) begin
      if (slot_done_o) begin
        cnt_d   = '0;
        digit_d = wrap_o ? '0 : digit_q + DW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign digit_o     = digit_q;
  assign digit_nxt_o = digit_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner with dead-time and frame-synchronous shadowing.
// Build option: define LZ_BLANK_EN for leading-zero suppression.
module display_scan_ctrl #(
  parameter int  NUM_DIGITS   = 4,
  parameter int  PRESCALE     = 1024,
  parameter int  BLANK_CYCLES = 16,
  localparam int DW           = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digit_bcd,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   cathode_n,
  output logic                    frame_tick,
  output logic [DW-1:0]           cur_digit
);
  import display_pkg::*;

  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [6:0]              seg_q, seg_on;
  logic [NUM_DIGITS-1:0]   cathode_q;
  logic                    frame_tick_q;
  logic                    run, clear, load;
  logic                    blank_done, slot_done, wrap;
  logic [DW-1:0]           digit_q, digit_nxt;
  logic [3:0]              cur_bcd;

  assign run   = enable && (state_q != IDLE);
  assign clear = !run;

  scan_prescaler #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_prescaler (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clear),
    .run_i       (run),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done),
    .wrap_o      (wrap),
    .digit_o     (digit_q),
    .digit_nxt_o (digit_nxt)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = BLANK;
        BLANK:   if (blank_done) state_d = ON;
        ON:      if (slot_done) state_d = BLANK;
        default: state_d = IDLE;
      endcase
    end
  end

  // Capture only on entry to digit 0's dead-time, so each frame loads once.
  assign load    = (state_d == BLANK) && ((state_q == IDLE) || ((state_q == ON) && wrap));
  assign cur_bcd = shadow_q[{digit_nxt, 2'b00} +: 4];

`ifdef LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask_q, lz_mask_d;
  logic                  zeros_above;

  always_comb begin
    lz_mask_d   = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeros_above  = zeros_above && (digit_bcd[4*i +: 4] == 4'd0);
      lz_mask_d[i] = zeros_above;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     lz_mask_q <= '0;
    else if (load) lz_mask_q <= lz_mask_d;
  end

  assign seg_on = lz_mask_q[digit_nxt] ? SEG_OFF : bcd_to_seg(cur_bcd);
`else
  assign seg_on = bcd_to_seg(cur_bcd);
`endif

  // Outputs are driven from next-state so the pins line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      seg_q        <= SEG_OFF;
      cathode_q    <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= load;
      if (load) shadow_q <= digit_bcd;
      if (state_d == ON) begin
        seg_q     <= seg_on;
        cathode_q <= ~(NUM_DIGITS'(1) << digit_nxt);
      end else begin
        seg_q     <= SEG_OFF;
        cathode_q <= '1;
      end
    end
  end

  assign seg        = seg_q;
  assign cathode_n  = cathode_q;
  assign frame_tick = frame_tick_q;
  assign cur_digit  = digit_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a time-based
// model of the scan schedule (frame position derived from elapsed cycles).
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   digit_bcd;
  logic [6:0]    seg;
  logic [3:0]    cathode_n;
  logic          frame_tick;
  logic [1:0]    cur_digit;

  int errors = 0;
  int checks = 0;

  bit         m_run = 0;
  int         m_t = 0;
  logic [15:0] m_shadow = '0;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .PRESCALE    (PS),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digit_bcd (digit_bcd),
    .seg       (seg),
    .cathode_n (cathode_n),
    .frame_tick(frame_tick),
    .cur_digit (cur_digit)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic bit ref_suppressed(input logic [15:0] v, input int idx);
    if (idx == 0) return 1'b0;
    for (int j = idx; j < ND; j++)
      if (v[4*j +: 4] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    if (reset || !enable) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run    = 1;
      m_t      = 0;
      m_shadow = digit_bcd;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) m_shadow = digit_bcd;
    end
  endtask

  task automatic compare_outputs();
    logic [6:0] e_seg;
    logic [3:0] e_cath;
    logic       e_tick;
    int         slot, phase;
    e_seg  = 7'h00;
    e_cath = 4'hF;
    e_tick = 1'b0;
    slot   = 0;
    if (m_run) begin
      slot   = (m_t % FRAME) / PS;
      phase  = m_t % PS;
      e_tick = (m_t % FRAME == 0);
      if (phase >= BC) begin
        e_cath = 4'hF & ~(4'(1) << slot);
        e_seg  = ref_decode(m_shadow[4*slot +: 4]);
`ifdef LZ_BLANK_EN
        if (ref_suppressed(m_shadow, slot)) e_seg = 7'h00;
`endif
      end
    end
    check("seg", 32'(seg), 32'(e_seg));
    check("cathode_n", 32'(cathode_n), 32'(e_cath));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("cur_digit", 32'(cur_digit), 32'(slot));
    check("cathode_onehot", 32'($countones(~cathode_n) <= 1), 32'd1);
    check("blank_seg_off", 32'((cathode_n != 4'hF) || (seg == 7'h00)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < ND; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    digit_bcd = 16'h0000;
    #1;
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_cathode", 32'(cathode_n), 32'hF);
    run_cycles(3);
    reset = 1'b0;
    run_cycles(2);

    // Basic scan of 1234.
    digit_bcd = 16'h1234;
    enable    = 1'b1;
    run_cycles(2 * FRAME);

    // Mid-frame change only takes effect at the next frame.
    for (int k = 0; k < FRAME && !(m_run && (m_t % FRAME == 10)); k++) cycle();
    digit_bcd = 16'h9999;
    run_cycles(FRAME + 8);

    // Invalid codes and leading zeros.
    digit_bcd = 16'h00AF;
    run_cycles(2 * FRAME + 4);

    // Drop enable during ON phase of digit 2.
    for (int k = 0; k < FRAME && !(m_run && ((m_t % FRAME) / PS == 2) && (m_t % PS >= BC + 1)); k++) cycle();
    enable = 1'b0;
    run_cycles(5);
    enable = 1'b1;
    run_cycles(FRAME + 3);

    // All zeros.
    digit_bcd = 16'h0000;
    run_cycles(2 * FRAME);

    // Asynchronous reset in the middle of an ON phase.
    for (int k = 0; k < FRAME && !(m_run && (m_t % PS == BC + 2)); k++) cycle();
    reset = 1'b1;
    #1;
    check("async_rst_cathode", 32'(cathode_n), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h0);
    check("async_rst_tick", 32'(frame_tick), 32'h0);
    check("async_rst_digit", 32'(cur_digit), 32'h0);
    m_run = 0;
    run_cycles(2);
    reset = 1'b0;
    run_cycles(FRAME);

    // Randomized traffic with occasional enable drops.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) digit_bcd = rand_bcd();
      if ($urandom_range(0, 59) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
